slc3_io_bridge: RTL
===================

Name: slc3_io_bridge

Overview:
- Sits between the SLC-3 datapath memory bus and the on-chip memory, switches and hex-display register.
- Decodes the memory-mapped I/O address and inserts memory wait states with a Ready handshake.
- Synchronises SW and the raw active-low Run/Continue buttons into the CPU clock domain, and emits single-cycle press pulses that feed the CPU control FSM.

Parameters:
WAIT_STATES, 2, extra cycles Mem_CE is held before read data is valid (0..7)
IO_ADDR, 16'hFFFF, address decoded as switch read / hex write
SYNC_STAGES, 2, flop depth of every input synchroniser (>=2)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
SW  in  10  raw slide switches
Run_n  in  1  raw Run button, active low
Continue_n  in  1  raw Continue button, active low
Run_pulse  out  1  one-cycle pulse per Run press
Continue_pulse  out  1  one-cycle pulse per Continue press
ADDR  in  16  CPU address (MAR)
Data_from_CPU  in  16  CPU write data (MDR)
MEM_OE  in  1  CPU read request, level
MEM_WE  in  1  CPU write request, level
Data_to_CPU  out  16  read data, held until next read completes
Ready  out  1  one-cycle access-complete strobe
Mem_Addr  out  16  memory address
Mem_Wdata  out  16  memory write data
Mem_Rdata  in  16  memory read data
Mem_CE  out  1  memory chip enable
Mem_WE  out  1  memory write enable
Hex_Data  out  16  value driven to the HEX0-3 decoders

Behaviour:
- Reset (sampled on Clk rising edge):
  - State goes to IDLE.
  - Outputs clear: Data_to_CPU=0, Hex_Data=0, Ready=0, Mem_CE=0, Mem_WE=0, pulses=0.
  - Synchroniser flops load 1 for the buttons and 0 for SW.
  - The arm flag is set.
- Synchronisers:
  - SW, Run_n and Continue_n each pass through SYNC_STAGES flops.
  - A pulse fires for one cycle on a synced 1->0 transition.
  - Press-to-pulse latency is SYNC_STAGES+1 cycles.
  - Holding a button low produces exactly one pulse.
- FSM states: IDLE, MEM_ACC, IO_ACC, DONE.
- IDLE:
  - A request (MEM_OE|MEM_WE) is accepted only while arm=1; acceptance clears arm.
  - Arm is set again in any cycle where both MEM_OE and MEM_WE are 0.
  - ADDR, Data_from_CPU and the write flag are latched on acceptance. If MEM_OE and MEM_WE are both high, the access is a write.
  - ADDR==IO_ADDR goes to IO_ACC; any other address goes to MEM_ACC.
- MEM_ACC:
  - Lasts exactly WAIT_STATES+1 cycles, tracked by a 3-bit counter.
  - Mem_CE=1 throughout; Mem_WE=write flag throughout.
  - Mem_Addr and Mem_Wdata are driven from the latched values.
  - On a read, Mem_Rdata is captured into Data_to_CPU on the final edge of MEM_ACC.
- IO_ACC:
  - Lasts 1 cycle; Mem_CE stays 0.
  - Read: Data_to_CPU <= {6'b0, SW_sync}.
  - Write: Hex_Data <= latched data.
- DONE:
  - Lasts 1 cycle with Ready=1, then returns to IDLE.
- Latency from the request-sampling edge to Ready high:
  - Memory access: WAIT_STATES+2 cycles.
  - I/O access: 2 cycles.
- A request still held after Ready is not re-accepted until it drops for at least one cycle.
- Reset mid-access:
  - The access is abandoned with no Ready and no Hex_Data or memory write.
  - Arm=1 after reset, so a request still held is accepted as a fresh access.
- Request-line changes during MEM_ACC or IO_ACC are ignored; the latched values are used.
- Hex_Data changes only on an IO_ADDR write.
- Data_to_CPU changes only on completed reads.

Decomposition:
- Package slc3_io_pkg holds:
  - state enum io_state_t {IDLE, MEM_ACC, IO_ACC, DONE};
  - constants IO_SW_HEX_ADDR=16'hFFFF and DEFAULT_WAIT_STATES=2.
- Sub-module sync_pulse (parameter SYNC_STAGES, width 1, optional pulse-on-fall output):
  - instantiated for Run_n and Continue_n;
  - a 10-bit generate loop of sync-only instances covers SW.

Test Plan:
- Reset with all inputs idle -> Hex_Data=0x0000, Data_to_CPU=0x0000, Ready=0, Mem_CE=0 on the first post-reset cycle.
- Read at ADDR=0x3000 with Mem_Rdata=0x1234 and WAIT_STATES=2 -> Mem_CE high for exactly 3 cycles, Mem_WE=0, Ready high in cycle 4 after the sampling edge, Data_to_CPU=0x1234 held afterwards.
- SW=0x002, read at ADDR=0xFFFF -> Mem_CE never high, Ready in cycle 2, Data_to_CPU=0x0002. Then write 0x00AB to 0xFFFF -> Hex_Data=0x00AB.
- Write 0x5A5A to ADDR=0x3001 -> Mem_WE=Mem_CE=1 for 3 cycles with Mem_Wdata=0x5A5A, Hex_Data unchanged. MEM_WE held high 10 cycles after Ready -> no second access.
- Continue_n held low 50 cycles -> exactly one Continue_pulse, 3 cycles after the falling edge. A 2nd press after release -> a 2nd pulse. Run_pulse stays 0 throughout.
- Reset asserted during cycle 2 of MEM_ACC with MEM_OE held -> no Ready, Mem_CE=0 the cycle after reset. After reset drops, a fresh read completes with Ready WAIT_STATES+2 cycles later.

Source files
------------

// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 memory / I/O bridge.
package slc3_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM_ACC,
        IO_ACC,
        DONE
    } io_state_t;

    localparam logic [15:0] IO_SW_HEX_ADDR      = 16'hFFFF;
    localparam int          DEFAULT_WAIT_STATES = 2;

endpackage

// File: rtl/sync_pulse.sv
// Multi-flop input synchroniser with an optional one-cycle pulse on a synced 1->0 edge.
module sync_pulse #(
    parameter int   SYNC_STAGES  = 2,
    parameter logic RESET_VALUE  = 1'b0,
    parameter bit   PULSE_ENABLE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift the raw input through the synchroniser chain; oldest sample sits at the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = stages[SYNC_STAGES-1];

    generate
        if (PULSE_ENABLE) begin : g_pulse
            logic dout_q;

            // Remember the previous synced level and register a pulse when it falls.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q     <= RESET_VALUE;
                    fall_pulse <= 1'b0;
                end else begin
                    dout_q     <= dout;
                    fall_pulse <= dout_q & ~dout;
                end
            end
        end else begin : g_no_pulse
            assign fall_pulse = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/slc3_io_bridge.sv
// SLC-3 bus bridge: memory wait states, switch/hex I/O decode and button press pulses.
module slc3_io_bridge
    import slc3_io_pkg::*;
#(
    parameter int          WAIT_STATES = DEFAULT_WAIT_STATES,
    parameter logic [15:0] IO_ADDR     = IO_SW_HEX_ADDR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  SW,
    input  logic        Run_n,
    input  logic        Continue_n,
    output logic        Run_pulse,
    output logic        Continue_pulse,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_Wdata,
    input  logic [15:0] Mem_Rdata,
    output logic        Mem_CE,
    output logic        Mem_WE,
    output logic [15:0] Hex_Data
);

    localparam logic [2:0] LAST_WAIT = 3'(WAIT_STATES);

    io_state_t   state;
    io_state_t   state_next;
    logic        arm;
    logic        write_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0]  wait_count;
    logic        request;
    logic        accept;
    logic        last_wait;
    logic [9:0]  sw_sync;
    logic [9:0]  sw_fall_unused;
    logic        run_level_unused;
    logic        cont_level_unused;

    sync_pulse #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1),
        .PULSE_ENABLE(1'b1)
    ) u_run_sync (
        .clk       (Clk),
        .reset     (Reset),
        .din       (Run_n),
        .dout      (run_level_unused),
        .fall_pulse(Run_pulse)
    );

    sync_pulse #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1),
        .PULSE_ENABLE(1'b1)
    ) u_cont_sync (
        .clk       (Clk),
        .reset     (Reset),
        .din       (Continue_n),
        .dout      (cont_level_unused),
        .fall_pulse(Continue_pulse)
    );

    for (genvar i = 0; i < 10; i++) begin : g_sw
        sync_pulse #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VALUE (1'b0),
            .PULSE_ENABLE(1'b0)
        ) u_sw_sync (
            .clk       (Clk),
            .reset     (Reset),
            .din       (SW[i]),
            .dout      (sw_sync[i]),
            .fall_pulse(sw_fall_unused[i])
        );
    end

    assign request   = MEM_OE | MEM_WE;
    assign accept    = (state == IDLE) && arm && request;
    assign last_wait = (wait_count == LAST_WAIT);
    assign Mem_Addr  = addr_q;
    assign Mem_Wdata = wdata_q;

    // Access sequencer state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Route an accepted request to memory or I/O, then finish through DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (ADDR == IO_ADDR) ? IO_ACC : MEM_ACC;
            MEM_ACC: if (last_wait) state_next = DONE;
            IO_ACC:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes follow MEM_ACC; Ready is the single DONE cycle.
    always_comb begin
        Ready  = (state == DONE);
        Mem_CE = (state == MEM_ACC);
        Mem_WE = (state == MEM_ACC) && write_q;
    end

    // Request latching, re-arm tracking, wait counting and read/hex result registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            arm         <= 1'b1;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_count  <= '0;
            Data_to_CPU <= '0;
            Hex_Data    <= '0;
        end else begin
            if (!request) begin
                arm <= 1'b1;
            end else if (accept) begin
                arm <= 1'b0;
            end

            if (accept) begin
                addr_q     <= ADDR;
                wdata_q    <= Data_from_CPU;
                write_q    <= MEM_WE;
                wait_count <= '0;
            end else if (state == MEM_ACC) begin
                wait_count <= wait_count + 3'd1;
            end

            if ((state == MEM_ACC) && last_wait && !write_q) begin
                Data_to_CPU <= Mem_Rdata;
            end

            if (state == IO_ACC) begin
                if (write_q) begin
                    Hex_Data <= wdata_q;
                end else begin
                    Data_to_CPU <= {6'b0, sw_sync};
                end
            end
        end
    end

endmodule
